// File: rtl/payload_aligner_pkg.sv
// Shared types and constants for the payload aligner and its input arbiter.
package payload_aligner_pkg;

    localparam int unsigned packet_width_bytes = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_PKT,
        ARB_GAP
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   pointer,
    output logic [PTR_W-1:0]   grant,
    output logic               any_grant
);

    localparam int unsigned IW = PTR_W + 1;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        logic [IW-1:0] idx;
        grant     = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, pointer} + IW'(k);
            if (idx >= IW'(NUM_REQ)) begin
                idx = idx - IW'(NUM_REQ);
            end
            if (!any_grant && eligible[idx[PTR_W-1:0]]) begin
                grant     = idx[PTR_W-1:0];
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/payload_aligner_arb.sv
// Packet-level round-robin arbiter feeding one payload aligner from NUM_REQ beat sources.
module payload_aligner_arb
    import payload_aligner_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BEAT_BYTES = packet_width_bytes,
    parameter int unsigned MIN_GAP    = 2,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*BEAT_BYTES*8-1:0]   req_data,
    input  logic [NUM_REQ*BEAT_BYTES-1:0]     req_byte_enable,
    input  logic [NUM_REQ-1:0]                req_sop,
    input  logic [NUM_REQ-1:0]                req_eop,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              out_valid,
    output logic [BEAT_BYTES*8-1:0]           out_data,
    output logic [BEAT_BYTES-1:0]             out_byte_enable,
    output logic                              out_sop,
    output logic                              out_eop,
    output logic [$clog2(NUM_REQ)-1:0]        out_src,
    output logic                              err_timeout,
    output logic                              err_sop,
    output logic                              stray_drop
);

    localparam int unsigned DW         = BEAT_BYTES * 8;
    localparam int unsigned PTR_W      = $clog2(NUM_REQ);
    localparam int unsigned GAP_W      = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int unsigned GAP_LAST   = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;
    localparam int unsigned STALL_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned STALL_LAST = TIMEOUT - 1;
    localparam arb_state_e  AFTER_PKT  = (MIN_GAP == 0) ? ARB_IDLE : ARB_GAP;

    arb_state_e           state;
    logic [PTR_W-1:0]     grant;
    logic [PTR_W-1:0]     rr_ptr;
    logic [GAP_W-1:0]     gap_cnt;
    logic [STALL_W-1:0]   stall_cnt;
    logic                 first_done;

    logic [DW-1:0]         data_arr [NUM_REQ];
    logic [BEAT_BYTES-1:0] be_arr   [NUM_REQ];

    logic [NUM_REQ-1:0]   eligible_c;
    logic [NUM_REQ-1:0]   owned_c;
    logic [NUM_REQ-1:0]   stray_vec_c;
    logic [PTR_W-1:0]     arb_grant_c;
    logic                 arb_any_c;
    logic                 cur_valid_c;
    logic                 cur_sop_c;
    logic                 cur_eop_c;
    logic                 early_sop_c;
    logic                 accept_c;
    logic                 stall_hit_c;

    // Unflatten per-source beat payloads.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DW +: DW];
            be_arr[i]   = req_byte_enable[i*BEAT_BYTES +: BEAT_BYTES];
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .eligible  (eligible_c),
        .pointer   (rr_ptr),
        .grant     (arb_grant_c),
        .any_grant (arb_any_c)
    );

    // Accept/drop decisions and per-source ready for the current cycle.
    always_comb begin
        eligible_c = req_valid & req_sop;
        owned_c    = '0;
        if (state == ARB_PKT) begin
            owned_c[grant] = 1'b1;
        end
        cur_valid_c = req_valid[grant];
        cur_sop_c   = req_sop[grant];
        cur_eop_c   = req_eop[grant];
        early_sop_c = (state == ARB_PKT) && first_done && cur_valid_c && cur_sop_c;
        accept_c    = (state == ARB_PKT) && cur_valid_c && !early_sop_c;
        stall_hit_c = (state == ARB_PKT) && !cur_valid_c
                      && (stall_cnt == STALL_W'(STALL_LAST));
        stray_vec_c = req_valid & ~req_sop & ~owned_c;
        req_ready   = '0;
        if (rst_n) begin
            req_ready = stray_vec_c | (owned_c & {NUM_REQ{!early_sop_c}});
        end
    end

    // Arbitration FSM, counters and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ARB_IDLE;
            grant           <= '0;
            rr_ptr          <= '0;
            gap_cnt         <= '0;
            stall_cnt       <= '0;
            first_done      <= 1'b0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_byte_enable <= '0;
            out_sop         <= 1'b0;
            out_eop         <= 1'b0;
            out_src         <= '0;
            err_timeout     <= 1'b0;
            err_sop         <= 1'b0;
            stray_drop      <= 1'b0;
        end else begin
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_byte_enable <= '0;
            out_sop         <= 1'b0;
            out_eop         <= 1'b0;
            err_timeout     <= 1'b0;
            err_sop         <= 1'b0;
            stray_drop      <= |stray_vec_c;
            case (state)
                ARB_IDLE: begin
                    if (arb_any_c) begin
                        grant      <= arb_grant_c;
                        rr_ptr     <= (arb_grant_c == PTR_W'(NUM_REQ - 1)) ? '0
                                      : arb_grant_c + PTR_W'(1);
                        stall_cnt  <= '0;
                        first_done <= 1'b0;
                        state      <= ARB_PKT;
                    end
                end
                ARB_PKT: begin
                    if (accept_c) begin
                        out_valid       <= 1'b1;
                        out_data        <= data_arr[grant];
                        out_byte_enable <= be_arr[grant];
                        out_sop         <= cur_sop_c;
                        out_eop         <= cur_eop_c;
                        out_src         <= grant;
                        stall_cnt       <= '0;
                        first_done      <= 1'b1;
                        if (cur_eop_c) begin
                            gap_cnt <= '0;
                            state   <= AFTER_PKT;
                        end
                    end else if (early_sop_c || stall_hit_c) begin
                        out_valid   <= 1'b1;
                        out_eop     <= 1'b1;
                        out_src     <= grant;
                        err_sop     <= early_sop_c;
                        err_timeout <= stall_hit_c;
                        gap_cnt     <= '0;
                        state       <= AFTER_PKT;
                    end else if (!cur_valid_c) begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                end
                ARB_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        gap_cnt <= '0;
                        state   <= ARB_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_payload_aligner_arb.sv
// Randomised bench for payload_aligner_arb against a cycle-level packet model.
module tb_payload_aligner_arb;

    localparam int NR = 4;
    localparam int MG = 2;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*64-1:0] req_data = '0;
    logic [NR*8-1:0]  req_byte_enable = '0;
    logic [NR-1:0] req_sop = '0;
    logic [NR-1:0] req_eop = '0;
    logic [NR-1:0] req_ready;
    logic          out_valid;
    logic [63:0]   out_data;
    logic [7:0]    out_byte_enable;
    logic          out_sop;
    logic          out_eop;
    logic [1:0]    out_src;
    logic          err_timeout;
    logic          err_sop;
    logic          stray_drop;

    payload_aligner_arb #(
        .NUM_REQ(NR), .BEAT_BYTES(8), .MIN_GAP(MG), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_byte_enable(req_byte_enable),
        .req_sop(req_sop), .req_eop(req_eop), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_byte_enable(out_byte_enable),
        .out_sop(out_sop), .out_eop(out_eop), .out_src(out_src),
        .err_timeout(err_timeout), .err_sop(err_sop), .stray_drop(stray_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idle;
        logic [63:0] d;
        logic [7:0]  be;
        logic        s;
        logic        e;
    } item_t;

    item_t srcq [NR][$];
    int    idle_left [NR];
    bit    loaded [NR];
    bit    acc [NR];

    logic [NR-1:0] drv_v, drv_s, drv_e;
    logic [63:0]   drv_d  [NR];
    logic [7:0]    drv_be [NR];

    int total = 0;
    int bad   = 0;

    // Packet-level model: who owns the aligner, cooldown left, rotation point.
    int owner, cool, ptr, taken, stall;
    logic        m_valid, m_sop, m_eop, m_et, m_es, m_stray;
    logic [1:0]  m_src;
    logic [7:0]  m_be;
    logic [63:0] m_data;
    logic [NR-1:0] m_rdy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; cool = 0; ptr = 0; taken = 0; stall = 0;
        m_valid = 0; m_sop = 0; m_eop = 0; m_et = 0; m_es = 0; m_stray = 0;
        m_src = '0; m_be = '0; m_data = '0;
    endtask

    task automatic model_ready();
        for (int i = 0; i < NR; i++) begin
            if (owner == i) m_rdy[i] = !(taken > 0 && drv_v[i] && drv_s[i]);
            else            m_rdy[i] = drv_v[i] && !drv_s[i];
        end
    endtask

    task automatic model_step();
        bit fin;
        int o;
        m_valid = 0; m_sop = 0; m_eop = 0; m_be = '0; m_data = '0; m_et = 0; m_es = 0;
        m_stray = 0;
        for (int i = 0; i < NR; i++) begin
            acc[i] = drv_v[i] && m_rdy[i];
            if (i != owner && drv_v[i] && !drv_s[i]) m_stray = 1;
        end
        fin = 0;
        if (owner >= 0) begin
            o = owner;
            if (drv_v[o] && taken > 0 && drv_s[o]) begin
                m_valid = 1; m_eop = 1; m_es = 1; m_src = 2'(o); fin = 1;
            end else if (drv_v[o]) begin
                m_valid = 1; m_sop = drv_s[o]; m_eop = drv_e[o];
                m_be = drv_be[o]; m_data = drv_d[o]; m_src = 2'(o);
                taken++; stall = 0; fin = drv_e[o];
            end else begin
                stall++;
                if (stall >= TO) begin
                    m_valid = 1; m_eop = 1; m_et = 1; m_src = 2'(o); fin = 1;
                end
            end
            if (fin) begin owner = -1; cool = MG; end
        end else if (cool > 0) begin
            cool--;
        end else begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (ptr + k) % NR;
                if (owner < 0 && drv_v[c] && drv_s[c]) begin
                    owner = c; ptr = (c + 1) % NR; taken = 0; stall = 0;
                end
            end
        end
    endtask

    task automatic advance_sources();
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                void'(srcq[i].pop_front());
                loaded[i] = 0;
                acc[i] = 0;
            end
            if (!loaded[i] && srcq[i].size() > 0) begin
                idle_left[i] = srcq[i][0].idle;
                loaded[i] = 1;
            end
            if (loaded[i] && idle_left[i] == 0) begin
                drv_v[i] = 1; drv_s[i] = srcq[i][0].s; drv_e[i] = srcq[i][0].e;
                drv_d[i] = srcq[i][0].d; drv_be[i] = srcq[i][0].be;
            end else begin
                drv_v[i] = 0; drv_s[i] = 0; drv_e[i] = 0; drv_d[i] = '0; drv_be[i] = '0;
                if (idle_left[i] > 0) idle_left[i]--;
            end
            req_data[i*64 +: 64]       = drv_d[i];
            req_byte_enable[i*8 +: 8]  = drv_be[i];
        end
        req_valid = drv_v;
        req_sop   = drv_s;
        req_eop   = drv_e;
    endtask

    // One clock: check registered outputs, drive, check ready, advance model.
    task automatic step_cycle();
        logic [15:0] got_ctl, exp_ctl;
        got_ctl = {out_valid, out_sop, out_eop, out_src, err_timeout, err_sop, stray_drop, out_byte_enable};
        exp_ctl = {m_valid, m_sop, m_eop, m_src, m_et, m_es, m_stray, m_be};
        check_eq("out_ctl", 64'(got_ctl), 64'(exp_ctl));
        check_eq("out_data", out_data, m_data);
        advance_sources();
        #1;
        model_ready();
        check_eq("req_ready", 64'(req_ready), 64'(m_rdy));
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse_reset(input int hold);
        rst_n = 1'b0;
        #1;
        check_eq("rst_out", 64'({out_valid, out_sop, out_eop, err_timeout, err_sop, stray_drop}), 64'(0));
        check_eq("rst_ready", 64'(req_ready), 64'(0));
        model_reset();
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input int i, input int idle, input logic [63:0] d,
                        input logic [7:0] be, input logic s, input logic e);
        item_t it;
        it.idle = idle; it.d = d; it.be = be; it.s = s; it.e = e;
        srcq[i].push_back(it);
    endtask

    function automatic bit busy();
        bit b;
        b = (owner >= 0) || (cool > 0) || (drv_v != '0);
        for (int i = 0; i < NR; i++) if (srcq[i].size() > 0) b = 1;
        return b;
    endfunction

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (busy() && n < max_cyc) begin
            step_cycle();
            n++;
        end
        check_eq("drain_idle", 64'(busy()), 64'(0));
        repeat (3) step_cycle();
    endtask

    task automatic gen_packet(input int i);
        int len, r, idle;
        logic eop;
        len = $urandom_range(1, 4);
        r = $urandom_range(0, 99);
        if (r < 5) begin
            push(i, $urandom_range(0, 2), {$urandom, $urandom}, 8'($urandom), 1'b0, 1'($urandom));
        end else begin
            for (int b = 0; b < len; b++) begin
                idle = (b > 0 && $urandom_range(0, 99) < 3) ? 70 : $urandom_range(0, 2);
                eop = (b == len - 1) && !(r < 12);
                push(i, idle, {$urandom, $urandom}, 8'($urandom), b == 0, eop);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            idle_left[i] = 0; loaded[i] = 0; acc[i] = 0; drv_d[i] = '0; drv_be[i] = '0;
        end
        drv_v = '0; drv_s = '0; drv_e = '0;
        model_reset();
        @(negedge clk);
        pulse_reset(3);
        repeat (2) step_cycle();

        // 3-beat packet from source 0
        push(0, 0, 64'hA0A0_0000_0000_0001, 8'hFF, 1, 0);
        push(0, 0, 64'hA0A0_0000_0000_0002, 8'hFF, 0, 0);
        push(0, 0, 64'hA0A0_0000_0000_0003, 8'h3F, 0, 1);
        drain(60);

        // simultaneous sops from 1 and 3, twice
        for (int rep = 0; rep < 2; rep++) begin
            push(1, 0, 64'h1111_0000_0000_0000 + 64'(rep), 8'hFF, 1, 0);
            push(1, 0, 64'h1111_0000_0000_1000 + 64'(rep), 8'h0F, 0, 1);
            push(3, 0, 64'h3333_0000_0000_0000 + 64'(rep), 8'hFF, 1, 0);
            push(3, 0, 64'h3333_0000_0000_1000 + 64'(rep), 8'hF0, 0, 1);
            drain(60);
        end

        // stall past timeout, then tail beats become strays
        push(2, 0, 64'h2222_0000_0000_0001, 8'hFF, 1, 0);
        push(2, 70, 64'h2222_0000_0000_0002, 8'hFF, 0, 0);
        push(2, 0, 64'h2222_0000_0000_0003, 8'hFF, 0, 1);
        drain(200);

        // early sop on second beat; the sop beat starts a fresh packet
        push(0, 0, 64'hE0E0_0000_0000_0001, 8'hFF, 1, 0);
        push(0, 0, 64'hE0E0_0000_0000_0002, 8'hFF, 1, 0);
        push(0, 0, 64'hE0E0_0000_0000_0003, 8'hFF, 0, 0);
        push(0, 0, 64'hE0E0_0000_0000_0004, 8'h01, 0, 1);
        drain(60);

        // single-beat packet with partial enables
        push(3, 0, 64'h1122334455667788, 8'h0F, 1, 1);
        drain(40);

        // reset mid-packet, then tail strays and a clean packet
        push(1, 0, 64'h5555_0000_0000_0001, 8'hFF, 1, 0);
        push(1, 1, 64'h5555_0000_0000_0002, 8'hFF, 0, 0);
        push(1, 1, 64'h5555_0000_0000_0003, 8'hFF, 0, 0);
        push(1, 1, 64'h5555_0000_0000_0004, 8'hFF, 0, 1);
        repeat (5) step_cycle();
        pulse_reset(2);
        drain(60);
        push(1, 0, 64'h6666_0000_0000_0001, 8'hFF, 1, 0);
        push(1, 0, 64'h6666_0000_0000_0002, 8'h7F, 0, 1);
        drain(60);

        // random traffic from all sources
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (srcq[i].size() < 2) gen_packet(i);
            end
            step_cycle();
        end
        drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
